// File: rtl/stream_arb_pkg.sv
// Shared types for the packet-aware round-robin stream arbiter.
package stream_arb_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the lowest-index request at or above ptr wins,
// with the search wrapping past the top input.
module rr_pick #(
  parameter  int unsigned Clog2NumReq = 2,
  localparam int unsigned NumReq      = 2**Clog2NumReq
) (
  input  logic [NumReq-1:0]      req,
  input  logic [Clog2NumReq-1:0] ptr,
  output logic [NumReq-1:0]      gnt,
  output logic [Clog2NumReq-1:0] gnt_id
);
  logic [NumReq-1:0]      w_rot;
  logic                   w_found;
  logic [Clog2NumReq-1:0] w_off;

  always_comb begin
    w_rot   = '0;
    w_found = 1'b0;
    w_off   = '0;
    // The index sum is Clog2NumReq bits wide, so the rotation wraps for free.
    for (int i = 0; i < NumReq; i++) w_rot[i] = req[Clog2NumReq'(i) + ptr];
    for (int i = 0; i < NumReq; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = Clog2NumReq'(i);
      end
    end
    gnt_id = w_off + ptr;
    gnt    = w_found ? (NumReq'(1) << gnt_id) : '0;
  end
endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 valid/ready stream arbiter. A grant is held for a whole packet, priority
// rotates only at packet boundaries, and the output goes through a one-entry register.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int unsigned Clog2NumReq = 2,
  parameter  int unsigned DataWidth   = 8,
  localparam int unsigned NumReq      = 2**Clog2NumReq
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReq-1:0][DataWidth-1:0]  in_data_i,
  input  logic [NumReq-1:0]                 in_last_i,
  input  logic [NumReq-1:0]                 in_valid_i,
  output logic [NumReq-1:0]                 in_ready_o,
  output logic [DataWidth-1:0]              out_data_o,
  output logic                              out_last_o,
  output logic [Clog2NumReq-1:0]            out_id_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i
);
  arb_state_e             r_state;
  logic [Clog2NumReq-1:0] r_ptr;
  logic [Clog2NumReq-1:0] r_lock_id;
  logic [DataWidth-1:0]   r_out_data;
  logic                   r_out_last;
  logic [Clog2NumReq-1:0] r_out_id;
  logic                   r_out_valid;

  logic [NumReq-1:0]      w_gnt;
  logic [Clog2NumReq-1:0] w_gnt_id;
  logic [NumReq-1:0]      w_sel;
  logic [Clog2NumReq-1:0] w_sel_id;
  logic                   w_load;
  logic                   w_any;
  logic                   w_sel_last;

  rr_pick #(.Clog2NumReq(Clog2NumReq)) u_pick (
    .req    (in_valid_i),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign w_load     = ~r_out_valid | out_ready_i;
  assign w_sel      = (r_state == IDLE) ? w_gnt
                                        : ((NumReq'(1) << r_lock_id) & in_valid_i);
  assign w_sel_id   = (r_state == IDLE) ? w_gnt_id : r_lock_id;
  assign w_any      = |w_sel;
  assign w_sel_last = in_last_i[w_sel_id];
  assign in_ready_o = w_load ? w_sel : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_lock_id   <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= in_data_i[w_sel_id];
        r_out_last <= w_sel_last;
        r_out_id   <= w_sel_id;
        case (r_state)
          IDLE: begin
            if (!w_sel_last) begin
              r_lock_id <= w_sel_id;
              r_state   <= LOCKED;
            end else begin
              r_ptr <= w_sel_id + 1'b1;
            end
          end
          LOCKED: begin
            if (w_sel_last) begin
              r_ptr   <= r_lock_id + 1'b1;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;
  assign out_id_o    = r_out_id;
  assign out_valid_o = r_out_valid;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios with literal expectations plus a
// randomized run compared cycle-by-cycle against a packet-level reference model.
module tb_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 8;

  logic                  clk = 1'b0;
  logic                  rst_i = 1'b0;
  logic [N-1:0][DW-1:0]  in_data_i = '0;
  logic [N-1:0]          in_last_i = '0;
  logic [N-1:0]          in_valid_i = '0;
  logic [N-1:0]          in_ready_o;
  logic [DW-1:0]         out_data_o;
  logic                  out_last_o;
  logic [IW-1:0]         out_id_o;
  logic                  out_valid_o;
  logic                  out_ready_i = 1'b0;

  stream_rr_arbiter #(.Clog2NumReq(IW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_data_i(in_data_i), .in_last_i(in_last_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .out_id_o(out_id_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  // Stimulus set by the scenarios, applied by step().
  logic                 rst;
  logic [N-1:0]         valid, last_v;
  logic [N-1:0][DW-1:0] data;
  logic                 oready;

  // Reference model: registered output plus packet ownership / next search start.
  bit       m_known = 0;
  bit       m_ov = 0;
  int       m_od = 0, m_ol = 0, m_oid = 0;
  int       m_owner = -1;
  int       m_start = 0;
  int       e_id;
  bit       load, acc;
  int       acc_id;

  typedef struct { int id; int data; int last; } beat_t;
  beat_t obs_q[$];

  int total = 0, bad = 0;

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    int exp_rdy;
    @(negedge clk);
    if (m_known) begin
      chk("out_valid", int'(out_valid_o), int'(m_ov));
      if (m_ov) begin
        chk("out_data", int'(out_data_o), m_od);
        chk("out_last", int'(out_last_o), m_ol);
        chk("out_id",   int'(out_id_o),   m_oid);
      end
    end
    if (out_valid_o && oready && !rst)
      obs_q.push_back('{int'(out_id_o), int'(out_data_o), int'(out_last_o)});
    rst_i = rst; in_valid_i = valid; in_last_i = last_v; in_data_i = data; out_ready_i = oready;
    #1;
    e_id = -1;
    if (m_owner >= 0) begin
      if (valid[m_owner]) e_id = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (e_id < 0 && valid[(m_start + k) % N]) e_id = (m_start + k) % N;
    end
    load    = !m_ov || oready;
    exp_rdy = (load && e_id >= 0) ? (1 << e_id) : 0;
    if (m_known) begin
      chk("in_ready", int'(in_ready_o), exp_rdy);
      chk("rdy_onehot", int'($countones(in_ready_o) > 1), 0);
    end
    acc    = !rst && load && e_id >= 0;
    acc_id = e_id;
    @(posedge clk);
    if (rst) begin
      m_known = 1; m_ov = 0; m_od = 0; m_ol = 0; m_oid = 0; m_owner = -1; m_start = 0;
    end else if (load) begin
      m_ov = (e_id >= 0);
      if (e_id >= 0) begin
        m_od = int'(data[e_id]); m_ol = int'(last_v[e_id]); m_oid = e_id;
        if (last_v[e_id]) begin
          m_owner = -1;
          m_start = (e_id + 1) % N;
        end else m_owner = e_id;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1; valid = '0; last_v = '0; data = '0; oready = 1;
    step(); step();
    rst = 0;
    obs_q.delete();
  endtask

  task automatic chk_obs(string nm, int idx, int id, int dat);
    if (obs_q.size() <= idx) chk({nm, "_missing"}, obs_q.size(), idx + 1);
    else begin
      chk({nm, "_id"}, obs_q[idx].id, id);
      chk({nm, "_data"}, obs_q[idx].data, dat);
    end
  endtask

  int seq[N], exp_seq[N], src_last[N], pkt_cnt[N];

  task automatic run_random(int cycles, bit sat);
    int   owner = -1;
    beat_t b;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; exp_seq[i] = 0; pkt_cnt[i] = 0; src_last[i] = int'($urandom_range(0, 1));
    end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        valid[i]  = sat ? 1'b1 : ($urandom_range(0, 3) != 0);
        data[i]   = DW'(i * 64 + seq[i] % 64);
        last_v[i] = src_last[i][0];
      end
      oready = sat ? 1'b1 : ($urandom_range(0, 3) != 0);
      step();
      if (acc) begin
        seq[acc_id]++;
        src_last[acc_id] = ($urandom_range(0, 2) == 0) ? 1 : 0;
      end
      while (obs_q.size() > 0) begin
        b = obs_q.pop_front();
        chk("id_tag", b.data / 64, b.id);
        chk("order", b.data % 64, exp_seq[b.id] % 64);
        exp_seq[b.id]++;
        chk("interleave", int'(owner >= 0 && owner != b.id), 0);
        owner = b.last ? -1 : b.id;
        if (b.last) pkt_cnt[b.id]++;
      end
    end
  endtask

  initial begin
    int exp1[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] held;
    int mx, mn;

    // Reset values
    apply_reset();
    #1;
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_out_data",  int'(out_data_o), 0);
    chk("rst_out_last",  int'(out_last_o), 0);
    chk("rst_out_id",    int'(out_id_o), 0);
    chk("rst_in_ready",  int'(in_ready_o), 0);

    // All inputs busy with single-beat packets: strict rotation from id 0
    valid = '1; last_v = '1; oready = 1;
    for (int i = 0; i < N; i++) data[i] = DW'(8'h10 + i);
    repeat (6) step();
    chk("rot_count", obs_q.size(), 5);
    for (int k = 0; k < 5; k++) chk_obs("rot", k, exp1[k], 8'h10 + exp1[k]);

    // Packet lock: input 2 sends 3 beats while input 0 keeps requesting
    apply_reset();
    valid = 4'b0100; data[2] = 8'hA0; last_v = 4'b0000;
    step();
    valid = 4'b0101; data[0] = 8'h05; last_v[0] = 1'b1; data[2] = 8'hA1;
    step();
    data[2] = 8'hA2; last_v[2] = 1'b1;
    step();
    valid = 4'b0001;
    repeat (3) step();
    chk_obs("pkt", 0, 2, 8'hA0);
    chk_obs("pkt", 1, 2, 8'hA1);
    chk_obs("pkt", 2, 2, 8'hA2);
    chk_obs("pkt", 3, 0, 8'h05);

    // Backpressure: register holds, nothing accepted
    valid = '1; last_v = '1; oready = 1;
    step();
    #1 held = out_data_o;
    chk("bp_loaded", int'(out_valid_o), 1);
    oready = 0;
    repeat (4) begin
      step();
      #1;
      chk("bp_hold", int'(out_data_o), int'(held));
      chk("bp_rdy", int'(in_ready_o), 0);
    end
    oready = 1;
    repeat (3) step();

    // Locked input 1 pauses mid-packet; input 3 must wait
    apply_reset();
    valid = 4'b0010; last_v = '0; data[1] = 8'hB0;
    step();
    valid = 4'b1010; data[3] = 8'h30; last_v[3] = 1'b1; data[1] = 8'hB1;
    step();
    valid = 4'b1000;
    repeat (2) step();
    valid = 4'b1010; data[1] = 8'hB2; last_v[1] = 1'b1;
    step();
    valid = 4'b1000;
    repeat (3) step();
    chk_obs("drop", 0, 1, 8'hB0);
    chk_obs("drop", 1, 1, 8'hB1);
    chk_obs("drop", 2, 1, 8'hB2);
    chk_obs("drop", 3, 3, 8'h30);

    // Reset during a locked packet
    apply_reset();
    valid = 4'b0100; last_v = '0; data[2] = 8'hA0;
    step();
    data[2] = 8'hA1; rst = 1;
    step();
    rst = 0;
    #1 chk("mid_rst_valid", int'(out_valid_o), 0);
    valid = '1; last_v = '1;
    for (int i = 0; i < N; i++) data[i] = DW'(8'h20 + i);
    obs_q.delete();
    repeat (2) step();
    chk_obs("restart", 0, 0, 8'h20);

    // Randomized traffic, then saturation for fairness
    apply_reset();
    run_random(8000, 1'b0);
    apply_reset();
    run_random(2000, 1'b1);
    mx = pkt_cnt[0]; mn = pkt_cnt[0];
    for (int i = 1; i < N; i++) begin
      if (pkt_cnt[i] > mx) mx = pkt_cnt[i];
      if (pkt_cnt[i] < mn) mn = pkt_cnt[i];
    end
    chk("fair_spread_ok", int'((mx - mn) <= 1), 1);
    chk("fair_nonzero", int'(mn > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
